// File: rtl/alarm_buzzer_ctrl_pkg.sv
// Shared types and default constants for the alarm buzzer controller.
// The snooze feature is enabled by defining ALARM_SNOOZE_EN.
package alarm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RING_ON  = 3'd1,
      ST_RING_OFF = 3'd2,
      ST_SNOOZE   = 3'd3,
      ST_TIMEOUT  = 3'd4
   } buzz_state_t;

   localparam int unsigned DEF_TONE_DIV    = 25000;
   localparam int unsigned DEF_TIMEOUT_SEC = 60;
   localparam int unsigned DEF_SNOOZE_SEC  = 300;
   localparam int unsigned DEF_MAX_SNOOZE  = 3;

   // Width able to hold 0..max_val, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/alarm_buzzer_ctrl_if.sv
// Control inputs and status outputs of the alarm buzzer controller.
// The master side drives the ticks, trigger and button; the slave side is the controller.
interface alarm_buzzer_ctrl_if;

   logic       clk_1hz_en;
   logic       alarm_trigger_in;
   logic       snooze_btn;
   logic       buzzer_out;
   logic       snooze_active_out;
   logic [2:0] snooze_count_out;
   logic       alarm_timeout_out;

   modport master (
      output clk_1hz_en,
      output alarm_trigger_in,
      output snooze_btn,
      input  buzzer_out,
      input  snooze_active_out,
      input  snooze_count_out,
      input  alarm_timeout_out
   );

   modport slave (
      input  clk_1hz_en,
      input  alarm_trigger_in,
      input  snooze_btn,
      output buzzer_out,
      output snooze_active_out,
      output snooze_count_out,
      output alarm_timeout_out
   );

endinterface

// File: rtl/alarm_buzzer_ctrl_tone_gen.sv
// Square-wave tone divider: toggles tone_out every TONE_DIV enabled cycles,
// and sits cleared with the output low whenever enable is low.
module tone_gen
   import alarm_pkg::*;
#(
   parameter int unsigned TONE_DIV = DEF_TONE_DIV
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic enable,
   output logic tone_out
);

   localparam int unsigned DIV_W = cnt_w(TONE_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tone_q, tone_d;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         tone_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tone_q <= tone_d;
      end
   end

   always_comb begin
      div_d  = div_q;
      tone_d = tone_q;
      if (!enable) begin
         div_d  = '0;
         tone_d = 1'b0;
      end else if (div_q == DIV_W'(TONE_DIV - 1)) begin
         div_d  = '0;
         tone_d = ~tone_q;
      end else begin
         div_d  = div_q + DIV_W'(1);
      end
   end

   assign tone_out = tone_q;

endmodule

// File: rtl/alarm_buzzer_ctrl.sv
// Alarm buzzer controller: gated 1 s on / 1 s off tone while the trigger is high,
// ring timeout auto-mute, and optional snooze handling built when ALARM_SNOOZE_EN is defined.
module alarm_buzzer_ctrl
   import alarm_pkg::*;
#(
   parameter int unsigned TONE_DIV    = DEF_TONE_DIV,
   parameter int unsigned TIMEOUT_SEC = DEF_TIMEOUT_SEC,
   parameter int unsigned SNOOZE_SEC  = DEF_SNOOZE_SEC,
   parameter int unsigned MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   alarm_buzzer_ctrl_if.slave bus
);

   localparam int unsigned RING_W = cnt_w(TIMEOUT_SEC);

   buzz_state_t       state_q, state_d;
   logic [RING_W-1:0] ring_sec_q, ring_sec_d;
   logic [RING_W-1:0] ring_inc;
   logic              timeout_hit;
   logic              snz_allowed;
   logic              snz_done;
   logic [2:0]        snz_count;
   logic              tone_raw;

   assign ring_inc    = ring_sec_q + RING_W'(1);
   assign timeout_hit = bus.clk_1hz_en && (ring_inc == RING_W'(TIMEOUT_SEC));

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ring_sec_q <= '0;
      end else begin
         state_q    <= state_d;
         ring_sec_q <= ring_sec_d;
      end
   end

   // Priority: trigger low, then timeout, then snooze edge, then beep toggle.
   always_comb begin
      state_d    = state_q;
      ring_sec_d = ring_sec_q;
      if (!bus.alarm_trigger_in) begin
         state_d    = ST_IDLE;
         ring_sec_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_RING_ON;
               ring_sec_d = '0;
            end
            ST_RING_ON, ST_RING_OFF: begin
               if (bus.clk_1hz_en) ring_sec_d = ring_inc;
               if (timeout_hit)
                  state_d = ST_TIMEOUT;
               else if (snz_allowed)
                  state_d = ST_SNOOZE;
               else if (bus.clk_1hz_en)
                  state_d = (state_q == ST_RING_ON) ? ST_RING_OFF : ST_RING_ON;
            end
            ST_SNOOZE: begin
               if (snz_done) begin
                  state_d    = ST_RING_ON;
                  ring_sec_d = '0;
               end
            end
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

`ifdef ALARM_SNOOZE_EN
   localparam int unsigned SNZ_W = cnt_w(SNOOZE_SEC);

   logic             btn_prev_q;
   logic [SNZ_W-1:0] snz_sec_q, snz_sec_d;
   logic [SNZ_W-1:0] snz_inc;
   logic [2:0]       snz_cnt_q, snz_cnt_d;
   logic             snz_edge;

   // The edge detector tracks the button in every state so a held button snoozes once.
   assign snz_edge    = bus.snooze_btn && !btn_prev_q;
   assign snz_allowed = snz_edge && (snz_cnt_q < 3'(MAX_SNOOZE));
   assign snz_inc     = snz_sec_q + SNZ_W'(1);
   assign snz_done    = bus.clk_1hz_en && (snz_inc == SNZ_W'(SNOOZE_SEC));
   assign snz_count   = snz_cnt_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev_q <= 1'b0;
         snz_sec_q  <= '0;
         snz_cnt_q  <= '0;
      end else begin
         btn_prev_q <= bus.snooze_btn;
         snz_sec_q  <= snz_sec_d;
         snz_cnt_q  <= snz_cnt_d;
      end
   end

   always_comb begin
      snz_sec_d = snz_sec_q;
      snz_cnt_d = snz_cnt_q;
      if (state_d == ST_IDLE) begin
         snz_sec_d = '0;
         snz_cnt_d = '0;
      end else if (state_q != ST_SNOOZE && state_d == ST_SNOOZE) begin
         snz_sec_d = '0;
         snz_cnt_d = snz_cnt_q + 3'd1;
      end else if (state_q == ST_SNOOZE && bus.clk_1hz_en) begin
         snz_sec_d = snz_inc;
      end
   end
`else
   assign snz_allowed = 1'b0;
   assign snz_done    = 1'b0;
   assign snz_count   = 3'd0;
`endif

   tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .enable   (state_q == ST_RING_ON),
      .tone_out (tone_raw)
   );

   // Gating by the registered state mutes the tone on the same edge that leaves RING_ON.
   assign bus.buzzer_out        = tone_raw && (state_q == ST_RING_ON);
   assign bus.snooze_active_out = (state_q == ST_SNOOZE);
   assign bus.snooze_count_out  = snz_count;
   assign bus.alarm_timeout_out = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Scoreboard bench for alarm_buzzer_ctrl: a behavioural model predicts the outputs
// after every clock edge and a monitor compares them against the DUT.
module tb_alarm_buzzer_ctrl;

   localparam int TD  = 4;
   localparam int TO  = 6;
   localparam int SS  = 5;
   localparam int MS  = 2;
   localparam int SEC = 20;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_ON   = 1;
   localparam int M_OFF  = 2;
   localparam int M_SNZ  = 3;
   localparam int M_TMO  = 4;

   typedef struct packed {
      logic       buz;
      logic       snz;
      logic [2:0] cnt;
      logic       tmo;
   } obs_t;

   logic sys_clk = 1'b0;
   logic rst_n;
   alarm_buzzer_ctrl_if bus ();

   alarm_buzzer_ctrl #(
      .TONE_DIV    (TD),
      .TIMEOUT_SEC (TO),
      .SNOOZE_SEC  (SS),
      .MAX_SNOOZE  (MS)
   ) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model state: alarm mode, seconds rung, seconds snoozed, snoozes used,
   // cycles spent in the current tone-on second, last button level.
   int m_mode, m_ring, m_snz, m_cnt, m_on;
   bit m_prev;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   task automatic clear_event();
      m_mode = M_IDLE;
      m_ring = 0;
      m_snz  = 0;
      m_cnt  = 0;
      m_on   = 0;
   endtask

   task automatic model_step(input bit trig, input bit tick, input bit btn);
      bit pressed;
      pressed = SNZ_EN && btn && !m_prev;
      m_prev  = btn;
      if (!trig) begin
         clear_event();
      end else begin
         case (m_mode)
            M_IDLE: begin
               m_mode = M_ON;
               m_ring = 0;
               m_on   = 0;
            end
            M_ON, M_OFF: begin
               if (tick && m_ring + 1 == TO) begin
                  m_mode = M_TMO;
               end else if (pressed && m_cnt < MS) begin
                  m_mode = M_SNZ;
                  m_cnt  = m_cnt + 1;
                  m_snz  = 0;
               end else if (tick) begin
                  m_ring = m_ring + 1;
                  if (m_mode == M_ON) m_mode = M_OFF;
                  else begin
                     m_mode = M_ON;
                     m_on   = 0;
                  end
               end else if (m_mode == M_ON) begin
                  m_on = m_on + 1;
               end
            end
            M_SNZ: begin
               if (tick) begin
                  m_snz = m_snz + 1;
                  if (m_snz == SS) begin
                     m_mode = M_ON;
                     m_ring = 0;
                     m_on   = 0;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.buz = (m_mode == M_ON) && ((m_on / TD) % 2 == 1);
      o.snz = (m_mode == M_SNZ);
      o.cnt = 3'(m_cnt);
      o.tmo = (m_mode == M_TMO);
      return o;
   endfunction

   // Reference model: advances on every rising edge and queues the expected outputs.
   initial begin
      forever begin
         @(posedge sys_clk);
         if (!rst_n) begin
            clear_event();
            m_prev = 1'b0;
         end else begin
            model_step(bus.alarm_trigger_in, bus.clk_1hz_en, bus.snooze_btn);
         end
         exp_q.push_back(model_obs());
      end
   end

   // Monitor: compares on the falling edge, away from the active edge.
   initial begin
      obs_t e;
      forever begin
         @(negedge sys_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst_n) e = '0;
            check("buzzer_out",        int'(bus.buzzer_out),        int'(e.buz));
            check("snooze_active_out", int'(bus.snooze_active_out), int'(e.snz));
            check("snooze_count_out",  int'(bus.snooze_count_out),  int'(e.cnt));
            check("alarm_timeout_out", int'(bus.alarm_timeout_out), int'(e.tmo));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   int ph;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
         ph = (ph + 1) % SEC;
         bus.clk_1hz_en = (ph == 0);
      end
   endtask

   task automatic secs(input int n);
      step(n * SEC);
   endtask

   task automatic press(input int hold);
      bus.snooze_btn = 1'b1;
      step(hold);
      bus.snooze_btn = 1'b0;
      step(1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_buzzer"},  int'(bus.buzzer_out),        0);
      check({tag, "_snz_act"}, int'(bus.snooze_active_out), 0);
      check({tag, "_snz_cnt"}, int'(bus.snooze_count_out),  0);
      check({tag, "_timeout"}, int'(bus.alarm_timeout_out), 0);
   endtask

   initial begin
      int n;
      rst_n                = 1'b0;
      bus.alarm_trigger_in = 1'b0;
      bus.snooze_btn       = 1'b0;
      bus.clk_1hz_en       = 1'b0;
      ph                   = 0;
      step(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      step(5);

      // Basic ring cadence
      bus.alarm_trigger_in = 1'b1;
      step(3 * SEC + $urandom_range(0, 19));
      bus.alarm_trigger_in = 1'b0;
      step(10);

      // Ring until timeout, then release
      bus.alarm_trigger_in = 1'b1;
      secs(8);
      bus.alarm_trigger_in = 1'b0;
      step(5);

      // Snooze at second 2 and resume
      bus.alarm_trigger_in = 1'b1;
      secs(2);
      press($urandom_range(1, 40));
      secs(12);
      bus.alarm_trigger_in = 1'b0;
      step(5);

      // Three presses, third over the limit
      bus.alarm_trigger_in = 1'b1;
      step($urandom_range(10, 30));
      press($urandom_range(1, 10));
      secs(6);
      press($urandom_range(1, 10));
      secs(6);
      step($urandom_range(0, 30));
      press($urandom_range(1, 10));
      secs(3);
      bus.alarm_trigger_in = 1'b0;
      step(5);

      // Trigger drop while snoozed, then two fresh snoozes
      bus.alarm_trigger_in = 1'b1;
      step(15);
      press(3);
      secs(2);
      bus.alarm_trigger_in = 1'b0;
      step(6);
      bus.alarm_trigger_in = 1'b1;
      secs(1);
      press(2);
      secs(6);
      press(2);
      secs(2);
      bus.alarm_trigger_in = 1'b0;
      step(5);

      // Snooze edge coincident with the sixth ring second
      bus.alarm_trigger_in = 1'b1;
      n = 0;
      while (n < TO) begin
         step(1);
         if (bus.clk_1hz_en) n++;
      end
      bus.snooze_btn = 1'b1;
      step(1);
      bus.snooze_btn = 1'b0;
      secs(2);
      bus.alarm_trigger_in = 1'b0;
      step(5);

      // Asynchronous reset in the middle of ringing
      bus.alarm_trigger_in = 1'b1;
      step($urandom_range(25, 60));
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      step(2);
      rst_n = 1'b1;
      step(40);
      bus.alarm_trigger_in = 1'b0;
      step(5);

      // Random trigger and button activity
      repeat (800) begin
         if ($urandom_range(0, 99) < 2) bus.alarm_trigger_in = ~bus.alarm_trigger_in;
         if ($urandom_range(0, 99) < 4) bus.snooze_btn = ~bus.snooze_btn;
         step(1);
      end
      bus.alarm_trigger_in = 1'b0;
      bus.snooze_btn       = 1'b0;
      step(3);
      @(negedge sys_clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_buzzer_ctrl.md
# alarm_buzzer_ctrl

Downstream consumer of the alarm comparator's trigger level. While the trigger is high, it drives the piezo buzzer with a gated square-wave tone (1 s on / 1 s off). It also handles snooze requests and auto-mutes the buzzer after a ring timeout. Status outputs go to the display/LED logic.

## Interface
- `TONE_DIV`, default 25000: sys_clk cycles per tone half-period (1 kHz at 50 MHz).
- `TIMEOUT_SEC`, default 60: seconds of ringing before auto-mute.
- `SNOOZE_SEC`, default 300: snooze length in seconds.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; legal range 0..7.
- `sys_clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clk_1hz_en`  in  1  one-cycle enable pulse, once per second.
- `alarm_trigger_in`  in  1  level from the comparator's `alarm_trigger_out`.
- `snooze_btn`  in  1  debounced, synchronous, level-high button.
- `buzzer_out`  out  1  tone output to the buzzer driver.
- `snooze_active_out`  out  1  high while in the SNOOZE state.
- `snooze_count_out`  out  3  snoozes used in the current alarm event.
- `alarm_timeout_out`  out  1  high while in the TIMEOUT state (muted).

## Operation
- **States:**
  - IDLE
  - RING_ON (tone gated on)
  - RING_OFF (tone gated off)
  - SNOOZE
  - TIMEOUT
- **IDLE → RING_ON:** when `alarm_trigger_in` is high. On entry, clear the ring-second counter and the tone divider.
- **Beep cadence:** RING_ON ↔ RING_OFF toggle on each `clk_1hz_en`.
- **Ring-second counter:**
  - Increments on `clk_1hz_en` in RING_ON and RING_OFF.
  - When an increment reaches `TIMEOUT_SEC`, go to TIMEOUT.
- **Snooze:**
  - An internal rising-edge detect on `snooze_btn` is active in RING_ON and RING_OFF.
  - If a rising edge occurs and `snooze_count < MAX_SNOOZE`: go to SNOOZE, increment `snooze_count`, clear the snooze-second counter.
  - If the count is already at the limit, the press is ignored and ringing continues.
- **SNOOZE:**
  - The snooze-second counter increments on `clk_1hz_en`.
  - When it reaches `SNOOZE_SEC`: go to RING_ON and clear the ring-second counter.
- **TIMEOUT:** hold, muted, until the trigger falls.
- **Trigger falls:** `alarm_trigger_in` low in any non-IDLE state → IDLE. All counters and `snooze_count` clear.
- **Priority within one cycle (highest first):**
  1. Trigger low.
  2. Timeout reached.
  3. Snooze edge.
  4. Beep toggle.
- **Tone divider:**
  - Counts 0..`TONE_DIV`-1 only in RING_ON; `buzzer_out` toggles at wrap.
  - Outside RING_ON: `buzzer_out` is forced 0 and the divider is held cleared.
- **Counter widths:** `$clog2(max+1)` of the respective parameter. Compare with `==` on the post-increment value; there is no wrap-around.

## Timing
- **Reset values:**
  - State is IDLE.
  - `buzzer_out`, `snooze_active_out`, `alarm_timeout_out` are 0.
  - `snooze_count_out` is 0.
  - All counters are 0.
- **Outputs:** all are registered or decoded from registered state; no combinational path from inputs.
- **Trigger rise:** sampled at edge N; state is RING_ON after edge N+1. The first `buzzer_out` rise occurs `TONE_DIV` cycles later.
- **Snooze response:** rising edge sampled at edge N; `snooze_active_out` is 1 after edge N+1. A button held high causes exactly one snooze.
- **Trigger fall:** all outputs return to reset values one cycle after the fall is sampled.
- **Mid-operation reset:** asynchronous return to reset values; no pending snooze survives.

## Configuration
- **`ALARM_SNOOZE_EN` defined:** snooze behaviour exactly as described above.
- **`ALARM_SNOOZE_EN` undefined:**
  - SNOOZE state, edge detect and snooze counters are not built.
  - `snooze_btn` is ignored.
  - `snooze_active_out` and `snooze_count_out` are tied to 0.

## Structure
- **Package `alarm_pkg`:**
  - State enum typedef `buzz_state_t`.
  - Default constants for `TONE_DIV`, `TIMEOUT_SEC`, `SNOOZE_SEC`, `MAX_SNOOZE`.
- **Sub-module `tone_gen`:**
  - Parameterized by `TONE_DIV`.
  - Inputs: `sys_clk`, `rst_n`, `enable`. Output: `tone_out`.
  - Clears and outputs 0 when `enable` is low.
- The top level holds the FSM, the second counters and the snooze logic.

## Test plan
All scenarios use `TONE_DIV`=4, `TIMEOUT_SEC`=6, `SNOOZE_SEC`=5, `MAX_SNOOZE`=2, with a `clk_1hz_en` pulse every 20 cycles.
- **Basic ring:**
  - Stimulus: raise trigger.
  - Response: `buzzer_out` toggles every 4 cycles during RING_ON, is 0 for 20 cycles in RING_OFF, and alternates per second.
- **Timeout:**
  - Stimulus: keep the trigger high for 6 pulses.
  - Response: `alarm_timeout_out` is 1 and `buzzer_out` is 0 until the trigger falls, then both are 0.
- **Snooze and resume:**
  - Stimulus: snooze edge at second 2.
  - Response: `snooze_active_out` is 1 and `snooze_count_out` is 1. After 5 pulses, RING_ON resumes and the ring counter restarts, so the timeout comes 6 s after resume.
- **Snooze limit:**
  - Stimulus: 3 snooze presses.
  - Response: the third is ignored, `snooze_count_out` stays 2 and ringing continues.
- **Trigger drop during snooze:**
  - Stimulus: drop the trigger while in SNOOZE.
  - Response: IDLE next cycle and `snooze_count_out` is 0. A new trigger allows 2 fresh snoozes.
- **Simultaneous events and reset:**
  - Stimulus: a snooze edge on the same cycle as the 6th pulse.
  - Response: TIMEOUT wins.
  - Stimulus: assert `rst_n` low mid-ring.
  - Response: all outputs are 0 immediately.
